// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard for long-latency results: tracks pending destination registers,
// stalls decode on RAW/WAW hazards against them, and flags writebacks with no pending owner.
module hazard_scoreboard #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter bit          WB_BYPASS       = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic        id_rs1_used_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        id_rs2_used_i,
   input  logic [4:0]  id_rd_addr_i,
   input  logic        id_reg_write_i,
   input  logic        id_long_lat_i,
   input  logic        issue_i,
   input  logic        flush_i,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   output logic        stall_o,
   output logic [31:0] pending_o,
   output logic [4:0]  outstanding_o,
   output logic        wb_err_o,
   output logic [31:0] stall_cycles_o
);

   localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

   logic [31:0] pending_q, pending_d;
   logic [4:0]  outstanding_q, outstanding_d;
   logic        wb_err_q, wb_err_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   logic clear, set;
   logic byp_rs1, byp_rs2, byp_rd;
   logic raw1, raw2, waw, full, stall;

   // Hazard detection; a writeback landing this cycle can unblock its register
   // because the register file is write-first.
   always_comb begin
      clear   = wb_valid_i && (wb_rd_i != 5'd0) && pending_q[wb_rd_i];
      byp_rs1 = WB_BYPASS && wb_valid_i && (wb_rd_i == id_rs1_addr_i);
      byp_rs2 = WB_BYPASS && wb_valid_i && (wb_rd_i == id_rs2_addr_i);
      byp_rd  = WB_BYPASS && wb_valid_i && (wb_rd_i == id_rd_addr_i);
      raw1    = id_valid_i && id_rs1_used_i && (id_rs1_addr_i != 5'd0)
                && pending_q[id_rs1_addr_i] && !byp_rs1;
      raw2    = id_valid_i && id_rs2_used_i && (id_rs2_addr_i != 5'd0)
                && pending_q[id_rs2_addr_i] && !byp_rs2;
      waw     = id_valid_i && id_reg_write_i && (id_rd_addr_i != 5'd0)
                && pending_q[id_rd_addr_i] && !byp_rd;
      full    = id_valid_i && id_long_lat_i && id_reg_write_i && (id_rd_addr_i != 5'd0)
                && (outstanding_q == MAX_CNT) && !clear;
      stall   = raw1 || raw2 || waw || full;
      set     = issue_i && id_valid_i && !flush_i && id_reg_write_i && id_long_lat_i
                && (id_rd_addr_i != 5'd0) && !stall;
   end

   // Next state: set is applied after clear so a same-register set wins.
   always_comb begin
      pending_d = pending_q;
      if (clear) pending_d[wb_rd_i] = 1'b0;
      if (set)   pending_d[id_rd_addr_i] = 1'b1;
      pending_d[0] = 1'b0;

      outstanding_d = outstanding_q;
      if (set && !clear)      outstanding_d = outstanding_q + 5'd1;
      else if (clear && !set) outstanding_d = outstanding_q - 5'd1;

      wb_err_d = wb_valid_i && (wb_rd_i != 5'd0) && !pending_q[wb_rd_i];

      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q      <= '0;
         outstanding_q  <= '0;
         wb_err_q       <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         pending_q      <= pending_d;
         outstanding_q  <= outstanding_d;
         wb_err_q       <= wb_err_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_o        = stall;
   assign pending_o      = pending_q;
   assign outstanding_o  = outstanding_q;
   assign wb_err_o       = wb_err_q;
   assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, checked by a
// scoreboard fed from a set-of-pending-registers reference model.
module tb_hazard_scoreboard;

   localparam int MAXO = 4;
   localparam bit BYP  = 1'b1;
   localparam int W    = 71;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ll;
      logic       iss;
      logic       fl;
      logic       wbv;
      logic [4:0] wbrd;
   } stim_t;

   logic        clk_i, rst_ni;
   logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_reg_write_i, id_long_lat_i;
   logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, wb_rd_i;
   logic        issue_i, flush_i, wb_valid_i;
   logic        stall_o, wb_err_o;
   logic [31:0] pending_o, stall_cycles_o;
   logic [4:0]  outstanding_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];

   // reference model state
   bit          pend_m[32];
   bit          err_m;
   logic [31:0] scnt_m;

   hazard_scoreboard #(.MAX_OUTSTANDING(MAXO), .WB_BYPASS(BYP)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_valid_i(id_valid_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_used_i(id_rs1_used_i),
      .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_used_i(id_rs2_used_i),
      .id_rd_addr_i(id_rd_addr_i), .id_reg_write_i(id_reg_write_i),
      .id_long_lat_i(id_long_lat_i), .issue_i(issue_i), .flush_i(flush_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
      .stall_o(stall_o), .pending_o(pending_o), .outstanding_o(outstanding_o),
      .wb_err_o(wb_err_o), .stall_cycles_o(stall_cycles_o)
   );

   // clock / reset block
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic stim_t st(input int v, input int rs1, input int u1, input int rs2,
                                input int u2, input int rd, input int rw, input int ll,
                                input int iss, input int fl, input int wbv, input int wbrd);
      stim_t s;
      s.v = (v != 0);     s.rs1 = 5'(rs1); s.u1 = (u1 != 0);
      s.rs2 = 5'(rs2);    s.u2 = (u2 != 0); s.rd = 5'(rd);
      s.rw = (rw != 0);   s.ll = (ll != 0); s.iss = (iss != 0);
      s.fl = (fl != 0);   s.wbv = (wbv != 0); s.wbrd = 5'(wbrd);
      return s;
   endfunction

   task automatic apply(input stim_t s);
      id_valid_i = s.v;   id_rs1_addr_i = s.rs1; id_rs1_used_i = s.u1;
      id_rs2_addr_i = s.rs2; id_rs2_used_i = s.u2; id_rd_addr_i = s.rd;
      id_reg_write_i = s.rw; id_long_lat_i = s.ll; issue_i = s.iss;
      flush_i = s.fl; wb_valid_i = s.wbv; wb_rd_i = s.wbrd;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
      err_m  = 1'b0;
      scnt_m = '0;
   endtask

   // Expected outputs for the cycle in which s is presented, then advance the model.
   task automatic model_step(input stim_t s, output logic [W-1:0] e);
      int cnt;
      logic [31:0] pv;
      bit clr, do_set, r1, r2, ww, fu, stall;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         cnt  += int'(pend_m[i]);
         pv[i] = pend_m[i];
      end
      clr = s.wbv && (s.wbrd != 0) && pend_m[s.wbrd];
      r1  = s.v && s.u1 && (s.rs1 != 0) && pend_m[s.rs1] && !(BYP && s.wbv && s.wbrd == s.rs1);
      r2  = s.v && s.u2 && (s.rs2 != 0) && pend_m[s.rs2] && !(BYP && s.wbv && s.wbrd == s.rs2);
      ww  = s.v && s.rw && (s.rd != 0) && pend_m[s.rd] && !(BYP && s.wbv && s.wbrd == s.rd);
      fu  = s.v && s.ll && s.rw && (s.rd != 0) && (cnt == MAXO) && !clr;
      stall = r1 || r2 || ww || fu;
      e = {stall, pv, 5'(cnt), err_m, scnt_m};
      do_set = s.iss && s.v && !s.fl && s.rw && s.ll && (s.rd != 0) && !stall;
      err_m  = s.wbv && (s.wbrd != 0) && !pend_m[s.wbrd];
      if (clr) pend_m[s.wbrd] = 1'b0;
      if (do_set) pend_m[s.rd] = 1'b1;
      if (stall && scnt_m != 32'hFFFF_FFFF) scnt_m = scnt_m + 32'd1;
   endtask

   // driver: one call per cycle, pushes the expected response
   task automatic drive(input stim_t s);
      logic [W-1:0] e;
      @(negedge clk_i);
      apply(s);
      model_step(s, e);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(negedge clk_i);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_o", {31'd0, stall_o}, {31'd0, e[70]});
            chk("pending_o", pending_o, e[69:38]);
            chk("outstanding_o", {27'd0, outstanding_o}, {27'd0, e[37:33]});
            chk("wb_err_o", {31'd0, wb_err_o}, {31'd0, e[32]});
            chk("stall_cycles_o", stall_cycles_o, e[31:0]);
         end
      end
   end

   initial begin : main
      stim_t idle, s;
      idle = st(0,0,0,0,0,0,0,0,0,0,0,0);
      apply(idle);
      model_reset();
      rst_ni = 1'b0;
      #12;
      chk("reset pending", pending_o, 32'h0);
      chk("reset outstanding", {27'd0, outstanding_o}, 32'd0);
      chk("reset stall_cycles", stall_cycles_o, 32'd0);
      chk("reset wb_err", {31'd0, wb_err_o}, 32'd0);
      rst_ni = 1'b1;

      // 1: load x5, RAW on rs1, released by same-cycle writeback
      drive(st(1,0,0,0,0,5,1,1,1,0,0,0));
      drive(st(1,5,1,0,0,6,1,0,1,0,0,0));
      #1;
      chk("t1 pending", pending_o, 32'h20);
      chk("t1 raw stall", {31'd0, stall_o}, 32'd1);
      drive(st(1,5,1,0,0,6,1,0,1,0,1,5));
      #1;
      chk("t1 bypass stall", {31'd0, stall_o}, 32'd0);
      drive(idle);
      #1;
      chk("t1 released", pending_o, 32'h0);

      // 2: WAW on x5
      drive(st(1,0,0,0,0,5,1,1,1,0,0,0));
      drive(st(1,0,0,0,0,5,1,0,1,0,0,0));
      drive(st(1,0,0,0,0,5,1,0,1,0,1,5));
      drive(idle);

      // 3: fill to MAX_OUTSTANDING, then full stall and same-cycle release
      for (int r = 1; r <= 4; r++) drive(st(1,0,0,0,0,r,1,1,1,0,0,0));
      drive(st(1,0,0,0,0,6,1,1,1,0,0,0));
      #1;
      chk("t3 outstanding", {27'd0, outstanding_o}, 32'd4);
      chk("t3 full stall", {31'd0, stall_o}, 32'd1);
      drive(st(1,0,0,0,0,6,1,1,1,0,1,1));
      #1;
      chk("t3 full released", {31'd0, stall_o}, 32'd0);
      drive(idle);
      #1;
      chk("t3 outstanding after swap", {27'd0, outstanding_o}, 32'd4);
      chk("t3 pending after swap", pending_o, 32'h5C);
      drive(st(0,0,0,0,0,0,0,0,0,0,1,2));
      drive(st(0,0,0,0,0,0,0,0,0,0,1,3));
      drive(st(0,0,0,0,0,0,0,0,0,0,1,4));
      drive(st(0,0,0,0,0,0,0,0,0,0,1,6));

      // 4: rd=x0, flushed issue, writeback to non-pending x9, writeback to x0
      drive(st(1,0,0,0,0,0,1,1,1,0,0,0));
      drive(st(1,0,0,0,0,8,1,1,1,1,0,0));
      drive(st(0,0,0,0,0,0,0,0,0,0,1,9));
      drive(idle);
      #1;
      chk("t4 wb_err pulse", {31'd0, wb_err_o}, 32'd1);
      drive(st(0,0,0,0,0,0,0,0,0,0,1,0));
      #1;
      chk("t4 wb_err one cycle", {31'd0, wb_err_o}, 32'd0);
      chk("t4 pending empty", pending_o, 32'h0);
      drive(idle);
      #1;
      chk("t4 no err on x0", {31'd0, wb_err_o}, 32'd0);

      // 5: set and clear x7 in one cycle
      drive(st(1,0,0,0,0,7,1,1,1,0,0,0));
      drive(st(1,0,0,0,0,7,1,1,1,0,1,7));
      #1;
      chk("t5 no stall", {31'd0, stall_o}, 32'd0);
      drive(idle);
      #1;
      chk("t5 x7 still pending", pending_o, 32'h80);
      chk("t5 outstanding", {27'd0, outstanding_o}, 32'd1);

      // 6: asynchronous reset with pending entries
      for (int r = 1; r <= 3; r++) drive(st(1,0,0,0,0,r,1,1,1,0,0,0));
      @(posedge clk_i);
      #1;
      apply(idle);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t6 async pending", pending_o, 32'h0);
      chk("t6 async outstanding", {27'd0, outstanding_o}, 32'd0);
      chk("t6 async stall_cycles", stall_cycles_o, 32'd0);
      chk("t6 async stall", {31'd0, stall_o}, 32'd0);
      model_reset();
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
      drive(st(1,3,1,0,0,0,0,0,1,0,0,0));
      #1;
      chk("t6 no stall after reset", {31'd0, stall_o}, 32'd0);

      // random traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         s.v    = ($urandom_range(0, 3) != 0);
         s.rs1  = 5'($urandom_range(0, 7));
         s.u1   = $urandom_range(0, 1) != 0;
         s.rs2  = 5'($urandom_range(0, 7));
         s.u2   = $urandom_range(0, 1) != 0;
         s.rd   = 5'($urandom_range(0, 7));
         s.rw   = ($urandom_range(0, 3) != 0);
         s.ll   = $urandom_range(0, 1) != 0;
         s.iss  = ($urandom_range(0, 3) != 0);
         s.fl   = ($urandom_range(0, 7) == 0);
         s.wbv  = ($urandom_range(0, 2) == 0);
         s.wbrd = 5'($urandom_range(0, 7));
         drive(s);
      end
      drive(idle);
      repeat (3) @(negedge clk_i);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
